vec_apu: RTL and testbench
==========================

VEC_APU -- requirements
Module: vec_apu

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning lane count (power of two, N >= 2).
REQ-002 The block SHALL have parameter W, default 8, meaning lane width in bits (W >= 2).
REQ-003 The block SHALL define L = clog2(N) (reduction depth) and DW = W + L (distance width).
REQ-004 Port clk  input  1  meaning the single clock; all logic on its rising edge.
REQ-005 Port reset  input  1  meaning synchronous, active-high reset.
REQ-006 Port start  input  1  meaning request; accepted only when busy = 0.
REQ-007 Port op  input  2  meaning opcode: 0 SUM, 1 AVG, 2 MAN, 3 MAX.
REQ-008 Port A  input  N x W packed  meaning operand vector A, unsigned lanes.
REQ-009 Port B  input  N x W packed  meaning operand vector B, unsigned lanes.
REQ-010 Port busy  output  1  meaning an operation is in progress.
REQ-011 Port done  output  1  meaning a one-cycle pulse: RES/DIST valid for the last accepted op.
REQ-012 Port RES  output  N x W packed  meaning registered lane-wise result.
REQ-013 Port DIST  output  DW  meaning registered Manhattan distance (MAN only).

Function
REQ-014 The FSM SHALL have the states IDLE, EXEC, REDUCE, DONE.
REQ-015 The FSM SHALL accept start in IDLE or DONE: latch A, B, op; next state EXEC.
REQ-016 In IDLE or DONE with start = 0, the next state SHALL be IDLE.
REQ-017 EXEC SHALL last one cycle: it registers the lane results into RES; next state REDUCE if op = MAN, else DONE.
REQ-018 SUM lane: RES[i] = (A[i] + B[i]) mod 2^W (wrap, no saturation).
REQ-019 AVG lane: RES[i] = (A[i] + B[i]) >> 1, computed in W+1 bits (carry preserved, truncating).
REQ-020 MAN lane: RES[i] = |A[i] - B[i]|, with no signed wrap.
REQ-021 MAX lane: RES[i] = max(A[i], B[i]).
REQ-022 REDUCE SHALL run a registered pairwise adder tree, one level per cycle, for exactly L cycles; the final sum is written to DIST; next state DONE.
REQ-023 Tree partial sums SHALL be widened by one bit per level, so DIST never overflows.
REQ-024 busy SHALL be 1 in EXEC and REDUCE, and 0 in IDLE and DONE.
REQ-025 done SHALL be 1 only in DONE, for exactly one cycle per accepted start.
REQ-026 Latency: start sampled at cycle k -> done at cycle k+2 (SUM/AVG/MAX) or k+2+L (MAN).
REQ-027 start while busy = 1 SHALL be ignored: no queuing; latched operands and op unchanged.
REQ-028 start in DONE SHALL be accepted (back-to-back); throughput is one op per 2 cycles (non-MAN).
REQ-029 RES and DIST SHALL hold their values until the next EXEC/REDUCE write; inputs A/B may change after acceptance with no effect.
REQ-030 Non-MAN ops SHALL leave DIST unchanged; MAN SHALL update both RES and DIST.

Reset
REQ-031 Reset SHALL force the state to IDLE and busy = 0, done = 0, RES = 0, DIST = 0, and clear the operand latches and the tree.
REQ-032 Reset SHALL take priority over start in the same cycle.
REQ-033 Reset mid-operation (EXEC/REDUCE) SHALL abort without a done pulse; the first start after reset deasserts behaves per REQ-026.

Verification (N=4, W=8, L=2)
REQ-034 SUM: A={250,10,3,100}, B={10,20,5,100}, start at k -> done at k+2, RES={4,30,8,200}.
REQ-035 AVG on the same operands -> RES={130,15,4,100}; A={255,...}, B={255,...} -> lane 255 (no carry loss).
REQ-036 MAN on the same operands -> RES={240,10,2,0}, done at k+4, DIST=252; all-255 vs all-0 -> DIST=1020.
REQ-037 MAX on the same operands -> RES={250,20,5,100}; a start pulse during MAN REDUCE is ignored, giving exactly one done.
REQ-038 Back-to-back: SUM then start held in DONE with op=MAX -> two done pulses 2 cycles apart, with correct RES each time.
REQ-039 Reset asserted in the REDUCE cycle of MAN -> no done; next cycle busy=0, RES=0, DIST=0.

Source files
------------

// File: rtl/vec_apu_if.sv
// Handshake and data bundle for vec_apu: the requester drives start/op/A/B,
// and the APU returns busy/done with the registered RES and DIST results.
interface vec_apu_if #(
   parameter int N = 4,
   parameter int W = 8
);
   localparam int DW = W + $clog2(N);

   logic                start;
   logic [1:0]          op;
   logic [N-1:0][W-1:0] A;
   logic [N-1:0][W-1:0] B;
   logic                busy;
   logic                done;
   logic [N-1:0][W-1:0] RES;
   logic [DW-1:0]       DIST;

   modport master (output start, op, A, B, input busy, done, RES, DIST);
   modport slave  (input start, op, A, B, output busy, done, RES, DIST);
endinterface

// File: rtl/vec_apu.sv
// Lane-wise vector ALU (SUM/AVG/MAN/MAX) with a registered pairwise adder
// tree that reduces the MAN lane distances to a single Manhattan distance.
module vec_apu #(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic       clk,
   input  logic       reset,
   vec_apu_if.slave   bus
);
   localparam int L  = $clog2(N);
   localparam int DW = W + L;
   localparam int CW = $clog2(L + 1);

   typedef enum logic [1:0] {IDLE, EXEC, REDUCE, DONE} state_t;

   state_t                  state_reg;
   logic [1:0]              op_reg;
   logic [N-1:0][W-1:0]     a_reg;
   logic [N-1:0][W-1:0]     b_reg;
   logic [N-1:0][W-1:0]     res_reg;
   logic [N-1:0][W-1:0]     lane_next;
   logic [N-1:0][W-1:0]     diff_next;
   logic [N-1:0][DW-1:0]    tree_reg;
   logic [N/2-1:0][DW-1:0]  pair_sum;
   logic [DW-1:0]           dist_reg;
   logic [CW-1:0]           cnt_reg;
   logic                    busy_reg;
   logic                    done_reg;

   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [W:0]   sum_w;
      logic [W-1:0] diff_w;
      logic [W-1:0] lane_w;

      // Sum kept at W+1 bits so AVG retains the carry before halving.
      assign sum_w  = {1'b0, a_reg[gi]} + {1'b0, b_reg[gi]};
      assign diff_w = (a_reg[gi] >= b_reg[gi]) ? (a_reg[gi] - b_reg[gi])
                                               : (b_reg[gi] - a_reg[gi]);
      always_comb begin
         lane_w = '0;
         case (op_reg)
            2'd0:    lane_w = sum_w[W-1:0];
            2'd1:    lane_w = sum_w[W:1];
            2'd2:    lane_w = diff_w;
            default: lane_w = (a_reg[gi] >= b_reg[gi]) ? a_reg[gi] : b_reg[gi];
         endcase
      end
      assign lane_next[gi] = lane_w;
      assign diff_next[gi] = diff_w;
   end

   // In-place tree: each level folds pairs into the lower half; after L levels
   // entry 0 holds the total. Entries are DW wide, so no level can overflow.
   for (genvar gi = 0; gi < N / 2; gi++) begin : g_pair
      assign pair_sum[gi] = tree_reg[2*gi] + tree_reg[2*gi+1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         op_reg    <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         res_reg   <= '0;
         tree_reg  <= '0;
         dist_reg  <= '0;
         cnt_reg   <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE, DONE: begin
               if (bus.start) begin
                  a_reg     <= bus.A;
                  b_reg     <= bus.B;
                  op_reg    <= bus.op;
                  busy_reg  <= 1'b1;
                  state_reg <= EXEC;
               end else begin
                  state_reg <= IDLE;
               end
            end
            EXEC: begin
               res_reg <= lane_next;
               if (op_reg == 2'd2) begin
                  for (int i = 0; i < N; i++) begin
                     tree_reg[i] <= DW'(diff_next[i]);
                  end
                  cnt_reg   <= '0;
                  state_reg <= REDUCE;
               end else begin
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end
            end
            REDUCE: begin
               for (int i = 0; i < N / 2; i++) begin
                  tree_reg[i] <= pair_sum[i];
               end
               if (cnt_reg == CW'(L - 1)) begin
                  dist_reg  <= pair_sum[0];
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_reg;
   assign bus.done = done_reg;
   assign bus.RES  = res_reg;
   assign bus.DIST = dist_reg;
endmodule

// File: tb/tb_vec_apu.sv
// Randomized self-checking bench for vec_apu against a lane-arithmetic model,
// plus directed operand sets, back-to-back, ignored-start and reset-abort cases.
module tb_vec_apu;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int L  = $clog2(N);
   localparam int DW = W + L;

   typedef logic [N-1:0][W-1:0] vec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vec_apu_if #(.N(N), .W(W)) bus ();
   vec_apu #(.N(N), .W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_checks = 0;
   int n_fail   = 0;
   logic [DW-1:0] exp_dist;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic vec_t rand_vec();
      vec_t v;
      for (int i = 0; i < N; i++) v[i] = W'($urandom);
      return v;
   endfunction

   function automatic vec_t model_res(input logic [1:0] o, input vec_t a, input vec_t b);
      vec_t r;
      for (int i = 0; i < N; i++) begin
         int x, y, v;
         x = int'(a[i]);
         y = int'(b[i]);
         case (o)
            2'd0:    v = (x + y) % (1 << W);
            2'd1:    v = (x + y) / 2;
            2'd2:    v = (x > y) ? x - y : y - x;
            default: v = (x > y) ? x : y;
         endcase
         r[i] = W'(v);
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] model_dist(input vec_t a, input vec_t b);
      int s;
      s = 0;
      for (int i = 0; i < N; i++) begin
         int x, y;
         x = int'(a[i]);
         y = int'(b[i]);
         s += (x > y) ? x - y : y - x;
      end
      return DW'(s);
   endfunction

   // Called at a falling edge; returns at the falling edge where done is seen
   // (or one cycle later when gap is set).
   task automatic do_op(input logic [1:0] o, input vec_t a, input vec_t b,
                        input bit gap, input bit poke);
      vec_t er;
      int   n;
      int   lat_exp;
      int   extra;
      er      = model_res(o, a, b);
      lat_exp = (o == 2'd2) ? 2 + L : 2;
      if (o == 2'd2) exp_dist = model_dist(a, b);
      bus.start = 1'b1;
      bus.op    = o;
      bus.A     = a;
      bus.B     = b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.op    = 2'($urandom);
      bus.A     = rand_vec();
      bus.B     = rand_vec();
      check("busy_after_start", 64'(bus.busy), 64'd1);
      n = 1;
      while (bus.done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
         if (poke && n == 2) begin
            bus.start = 1'b1;
            bus.op    = 2'd3;
            bus.A     = rand_vec();
            bus.B     = rand_vec();
         end else begin
            bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      check("latency", 64'(n), 64'(lat_exp));
      check("done_high", 64'(bus.done), 64'd1);
      check("busy_in_done", 64'(bus.busy), 64'd0);
      check("res", 64'(bus.RES), 64'(er));
      check("dist", 64'(bus.DIST), 64'(exp_dist));
      $display("op=%0d A=%h B=%h lat=%0d RES=%h DIST=%0d", o, a, b, n, bus.RES, bus.DIST);
      if (poke) begin
         extra = 0;
         repeat (5) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra++;
         end
         check("no_extra_done", 64'(extra), 64'd0);
         check("res_after_poke", 64'(bus.RES), 64'(er));
      end else if (gap) begin
         @(negedge clk);
         check("done_one_cycle", 64'(bus.done), 64'd0);
         check("busy_idle", 64'(bus.busy), 64'd0);
      end
   endtask

   initial begin
      vec_t a0, b0, ones, zeros, lit;
      int   dones;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op    = 2'd0;
      bus.A     = '0;
      bus.B     = '0;
      exp_dist  = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_res", 64'(bus.RES), 64'd0);
      check("rst_dist", 64'(bus.DIST), 64'd0);

      // Reset wins over a simultaneous start.
      bus.start = 1'b1;
      bus.A     = rand_vec();
      bus.B     = rand_vec();
      @(negedge clk);
      check("rst_prio_busy", 64'(bus.busy), 64'd0);
      bus.start = 1'b0;
      reset     = 1'b0;
      @(negedge clk);
      check("rst_prio_idle", 64'(bus.busy), 64'd0);

      a0    = {8'd250, 8'd10, 8'd3, 8'd100};
      b0    = {8'd10, 8'd20, 8'd5, 8'd100};
      ones  = {N{8'd255}};
      zeros = '0;

      do_op(2'd0, a0, b0, 1'b1, 1'b0);
      lit = {8'd4, 8'd30, 8'd8, 8'd200};
      check("sum_literal", 64'(bus.RES), 64'(lit));
      do_op(2'd1, a0, b0, 1'b1, 1'b0);
      lit = {8'd130, 8'd15, 8'd4, 8'd100};
      check("avg_literal", 64'(bus.RES), 64'(lit));
      do_op(2'd1, ones, ones, 1'b1, 1'b0);
      check("avg_carry_literal", 64'(bus.RES), 64'(ones));
      do_op(2'd2, a0, b0, 1'b1, 1'b0);
      lit = {8'd240, 8'd10, 8'd2, 8'd0};
      check("man_literal", 64'(bus.RES), 64'(lit));
      check("man_dist_literal", 64'(bus.DIST), 64'd252);
      do_op(2'd3, a0, b0, 1'b1, 1'b0);
      lit = {8'd250, 8'd20, 8'd5, 8'd100};
      check("max_literal", 64'(bus.RES), 64'(lit));
      do_op(2'd2, ones, zeros, 1'b1, 1'b1);
      check("man_dist_max", 64'(bus.DIST), 64'd1020);

      // Back-to-back: second start issued during the first op's done cycle.
      do_op(2'd0, a0, b0, 1'b0, 1'b0);
      do_op(2'd3, a0, b0, 1'b1, 1'b0);

      // Reset during the first REDUCE cycle of MAN aborts with no done.
      bus.start = 1'b1;
      bus.op    = 2'd2;
      bus.A     = rand_vec();
      bus.B     = rand_vec();
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_done", 64'(bus.done), 64'd0);
      check("abort_res", 64'(bus.RES), 64'd0);
      check("abort_dist", 64'(bus.DIST), 64'd0);
      reset    = 1'b0;
      exp_dist = '0;
      dones    = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.done === 1'b1) dones++;
      end
      check("abort_no_done", 64'(dones), 64'd0);

      for (int t = 0; t < 40; t++) begin
         do_op(2'($urandom), rand_vec(), rand_vec(), 1'($urandom), 1'b0);
      end
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
